// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand request from the master,
// status and result back from the adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start, A, B,
        input  busy, done, sum, carry
    );

    modport slave (
        input  start, A, B,
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, adding
// LSB-first over WIDTH cycles and publishing sum/carry with a done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] s_sr_r;
    logic             c_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             busy_s;
    logic             done_s;
    logic             bit_sum_s;
    logic             carry_next_s;
    logic [WIDTH-1:0] s_shift_s;
    logic [WIDTH:0]   s_cat_s;

    // Full-adder cell sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Full-adder cell carry: majority of the three inputs.
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    // Single-bit add step; the concatenation form stays legal when WIDTH is 1.
    always_comb begin
        bit_sum_s    = fa_sum(a_sr_r[0], b_sr_r[0], c_r);
        carry_next_s = fa_carry(a_sr_r[0], b_sr_r[0], c_r);
        s_cat_s      = {bit_sum_s, s_sr_r};
        s_shift_s    = s_cat_s[WIDTH:1];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; start only matters in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_BIT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode from registered state only.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, serial shifting, and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            s_sr_r  <= '0;
            c_r     <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_sr_r <= bus.A;
                        b_sr_r <= bus.B;
                        c_r    <= 1'b0;
                        cnt_r  <= '0;
                    end else begin
                        a_sr_r <= a_sr_r;
                    end
                end
                RUN: begin
                    a_sr_r <= a_sr_r >> 1;
                    b_sr_r <= b_sr_r >> 1;
                    s_sr_r <= s_shift_s;
                    c_r    <= carry_next_s;
                    if (cnt_r == LAST_BIT) begin
                        sum_r   <= s_shift_s;
                        carry_r <= carry_next_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_s;
    assign bus.done  = done_s;
    assign bus.sum   = sum_r;
    assign bus.carry = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hand-written
// sequences for reset, start-while-busy, back-to-back and mid-run reset.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst;
    logic clk_en;
    int   checks;
    int   failures;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one operation from IDLE; sampling is 1 time unit after each rising edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic ec);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = ~a; bus.B = ~b;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = cyc;
                break;
            end
            check("busy_during_run", {31'd0, bus.busy}, 32'd1);
        end
        check("latency", lat, W);
        check("sum", {24'd0, bus.sum}, {24'd0, es});
        check("carry", {31'd0, bus.carry}, {31'd0, ec});
        @(posedge clk); #1;
        check("done_falls", {31'd0, bus.done}, 32'd0);
        check("busy_falls", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        check("sum_hold", {23'd0, bus.carry, bus.sum}, {23'd0, ec, es});
    endtask

    initial begin
        int dones;
        checks = 0;
        failures = 0;
        clk_en = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;

        vecs[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b1};

        // Reset with the clock stopped.
        rst = 1'b1;
        #3;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", {24'd0, bus.sum}, 32'd0);
        check("rst_carry", {31'd0, bus.carry}, 32'd0);
        #4 rst = 1'b0;
        clk_en = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("rst_no_done", dones, 0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
        end

        // start while busy and operand changes during RUN are ignored.
        @(negedge clk);
        bus.A = 8'h10; bus.B = 8'h20; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = 8'hFF; bus.B = 8'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        for (int e = 4; e <= 16; e++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                check("robust_done_edge", e, W);
            end
        end
        check("robust_one_done", dones, 1);
        check("robust_sum", {24'd0, bus.sum}, 32'h30);
        check("robust_carry", {31'd0, bus.carry}, 32'd0);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.A = 8'h80; bus.B = 8'h80; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.A = 8'h01; bus.B = 8'h02;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
        end
        check("b2b_done1", {31'd0, bus.done}, 32'd1);
        check("b2b_sum1", {23'd0, bus.carry, bus.sum}, {23'd0, 1'b1, 8'h00});
        @(posedge clk); #1;
        check("b2b_idle9", {30'd0, bus.busy, bus.done}, 32'd0);
        @(posedge clk); #1;
        check("b2b_accept10", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        for (int e = 11; e <= 18; e++) begin
            @(posedge clk); #1;
        end
        check("b2b_done2", {31'd0, bus.done}, 32'd1);
        check("b2b_sum2", {23'd0, bus.carry, bus.sum}, {23'd0, 1'b0, 8'h03});
        @(posedge clk); #1;
        check("b2b_idle19", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.A = 8'hAA; bus.B = 8'h55; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_sum", {23'd0, bus.carry, bus.sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        run_op(8'h01, 8'h01, 8'h02, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
